// File: rtl/nt_bist_pkg.sv
// Shared types and constants for the Nt-node BIST stimulus driver.
package nt_bist_pkg;

  localparam int SIG_W = 16;

  localparam logic [SIG_W-1:0] LFSR_TAPS = 16'hB400;
  localparam logic [SIG_W-1:0] SEED_SUB  = 16'h0001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // One Fibonacci step: parity of the tapped bits (15,13,12,10) enters at bit 0.
  function automatic logic [SIG_W-1:0] lfsr_step(input logic [SIG_W-1:0] q);
    return {q[SIG_W-2:0], ^(q & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/nt_bist_lfsr16.sv
// Step-enabled 16-bit Fibonacci LFSR with parallel load and an XOR input;
// with xin tied to zero it is a pattern generator, otherwise a MISR.
module nt_bist_lfsr16
  import nt_bist_pkg::*;
#(
  parameter logic [SIG_W-1:0] RST_VAL = 16'h0001,
  parameter int               OUT_W   = SIG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [SIG_W-1:0] load_val,
  input  logic             step,
  input  logic [SIG_W-1:0] xin,
  output logic [OUT_W-1:0] nxt
);

  logic [SIG_W-1:0] q;
  logic [SIG_W-1:0] d;

  always_comb begin
    // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
    d = q;
    if (load) begin
      d = load_val;
    end else if (step) begin
      d = lfsr_step(q) ^ xin;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state is updated with <= so all flops sample the same pre-edge values.
    if (!rst_n) begin
      q <= RST_VAL;
    end else begin
      q <= d;
    end
  end

  // The next-state view lets the owner register outputs that line up with the new state.
  assign nxt = d[OUT_W-1:0];

endmodule

// File: rtl/nt_bist_stimulus_driver.sv
// BIST stimulus driver: LFSR patterns to one CUT, MISR compaction of its response.
// Optional golden-signature compare is built when NT_BIST_GOLDEN_CMP_EN is defined.
module nt_bist_stimulus_driver #(
  parameter int VEC_W   = 6,
  parameter int PAT_CNT = 1000,
  parameter int CUT_LAT = 2,
  parameter int SIG_W   = 16
) (
  input  logic             I1470,
  input  logic             I1477,
  input  logic             start,
  input  logic             abort,
  input  logic [SIG_W-1:0] seed,
  output logic [VEC_W-1:0] vec,
  output logic             vec_valid,
  input  logic             resp,
  output logic             busy,
  output logic             done,
  output logic [SIG_W-1:0] sig
`ifdef NT_BIST_GOLDEN_CMP_EN
  ,
  input  logic [SIG_W-1:0] golden,
  output logic [0:0]       pass
`endif
);

  import nt_bist_pkg::*;

  localparam logic [9:0] PAT_LAST   = 10'(PAT_CNT - 1);
  localparam logic [2:0] DRAIN_LAST = 3'(CUT_LAT - 1);

  state_t           state;
  logic [9:0]       pat_cnt;
  logic [2:0]       drain_cnt;
  logic             accept;
  logic             dly_valid;
  logic [SIG_W-1:0] seed_eff;
  logic [VEC_W-1:0] pat_nxt;
  logic [SIG_W-1:0] misr_nxt;

  assign accept   = (state == ST_IDLE) && start;
  assign seed_eff = (seed == '0) ? SEED_SUB : seed;

  nt_bist_lfsr16 #(
    .RST_VAL (SEED_SUB),
    .OUT_W   (VEC_W)
  ) u_pat_lfsr (
    .clk      (I1470),
    .rst_n    (I1477),
    .load     (accept),
    .load_val (seed_eff),
    .step     (state == ST_RUN),
    .xin      ('0),
    .nxt      (pat_nxt)
  );

  nt_bist_lfsr16 #(
    .RST_VAL ('0),
    .OUT_W   (SIG_W)
  ) u_misr (
    .clk      (I1470),
    .rst_n    (I1477),
    .load     (accept),
    .load_val ('0),
    .step     (dly_valid),
    .xin      ({{(SIG_W-1){1'b0}}, resp}),
    .nxt      (misr_nxt)
  );

  // Delayed copy of vec_valid marks the cycles in which resp belongs to a live pattern.
  generate
    if (CUT_LAT == 0) begin : g_no_pipe
      assign dly_valid = vec_valid;
    end else begin : g_pipe
      logic [CUT_LAT-1:0] vpipe;

      always_ff @(posedge I1470 or negedge I1477) begin
        if (!I1477) begin
          vpipe <= '0;
        end else if (abort && busy) begin
          vpipe <= '0;
        end else begin
          vpipe <= (vpipe << 1) | CUT_LAT'(vec_valid);
        end
      end

      assign dly_valid = vpipe[CUT_LAT-1];
    end
  endgenerate

  always_ff @(posedge I1470 or negedge I1477) begin
    if (!I1477) begin
      state     <= ST_IDLE;
      vec       <= '0;
      vec_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sig       <= '0;
      pat_cnt   <= '0;
      drain_cnt <= '0;
`ifdef NT_BIST_GOLDEN_CMP_EN
      pass      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_RUN;
            vec       <= pat_nxt;
            vec_valid <= 1'b1;
            busy      <= 1'b1;
            pat_cnt   <= '0;
`ifdef NT_BIST_GOLDEN_CMP_EN
            pass      <= 1'b0;
`endif
          end
        end

        ST_RUN: begin
          if (abort) begin
            state     <= ST_IDLE;
            vec       <= '0;
            vec_valid <= 1'b0;
            busy      <= 1'b0;
          end else if (pat_cnt == PAT_LAST) begin
            vec       <= '0;
            vec_valid <= 1'b0;
            if (CUT_LAT == 0) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              sig   <= misr_nxt;
            end else begin
              state     <= ST_DRAIN;
              drain_cnt <= '0;
            end
          end else begin
            pat_cnt <= pat_cnt + 10'd1;
            vec     <= pat_nxt;
          end
        end

        ST_DRAIN: begin
          if (abort) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (drain_cnt == DRAIN_LAST) begin
            // misr_nxt already includes the capture happening on this edge.
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            sig   <= misr_nxt;
          end else begin
            drain_cnt <= drain_cnt + 3'd1;
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
`ifdef NT_BIST_GOLDEN_CMP_EN
          pass  <= (misr_nxt == golden);
`endif
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nt_bist_stimulus_driver.sv
// Randomized scoreboard bench for nt_bist_stimulus_driver (PAT_CNT=4, CUT_LAT=2).
// Golden-compare checks are included when NT_BIST_GOLDEN_CMP_EN is defined.
module tb_nt_bist_stimulus_driver;

  localparam int VEC_W   = 6;
  localparam int PAT_CNT = 4;
  localparam int CUT_LAT = 2;
  localparam int SIG_W   = 16;
  localparam int RUN_LEN = PAT_CNT + CUT_LAT + 2;

  logic              I1470 = 1'b0;
  logic              I1477 = 1'b1;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              resp  = 1'b0;
  logic [SIG_W-1:0]  seed  = '0;
  logic [VEC_W-1:0]  vec;
  logic              vec_valid;
  logic              busy;
  logic              done;
  logic [SIG_W-1:0]  sig;
`ifdef NT_BIST_GOLDEN_CMP_EN
  logic [SIG_W-1:0]  golden = '0;
  logic [0:0]        pass;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [VEC_W-1:0] exp_vec_q[$];
  logic [SIG_W-1:0] exp_sig_q[$];

  bit               cut_en   = 1'b0;
  logic [VEC_W-1:0] cut_mask = '0;
  logic [SIG_W-1:0] last_sig = '0;

  nt_bist_stimulus_driver #(
    .VEC_W   (VEC_W),
    .PAT_CNT (PAT_CNT),
    .CUT_LAT (CUT_LAT),
    .SIG_W   (SIG_W)
  ) dut (
    .I1470     (I1470),
    .I1477     (I1477),
    .start     (start),
    .abort     (abort),
    .seed      (seed),
    .vec       (vec),
    .vec_valid (vec_valid),
    .resp      (resp),
    .busy      (busy),
    .done      (done),
    .sig       (sig)
`ifdef NT_BIST_GOLDEN_CMP_EN
    ,
    .golden    (golden),
    .pass      (pass)
`endif
  );

  always #5 I1470 = ~I1470;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference CUT: parity of the masked vector, seen CUT_LAT cycles later.
  function automatic logic cut_f(input logic [VEC_W-1:0] v);
    return ^(v & cut_mask);
  endfunction

  // Expected vectors (first nvec pushed to the scoreboard) and the final signature.
  function automatic logic [SIG_W-1:0] model_run(input logic [SIG_W-1:0] s, input int nvec);
    logic [SIG_W-1:0] lfsr;
    logic [SIG_W-1:0] misr;
    logic [VEC_W-1:0] v;
    logic             r;
    lfsr = (s == 16'h0000) ? 16'h0001 : s;
    misr = 16'h0000;
    for (int k = 0; k < PAT_CNT; k++) begin
      v = lfsr[VEC_W-1:0];
      if (k < nvec) exp_vec_q.push_back(v);
      r    = cut_en ? cut_f(v) : 1'b0;
      misr = {misr[14:0], misr[15] ^ misr[13] ^ misr[12] ^ misr[10]} ^ {15'b0, r};
      lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
    return misr;
  endfunction

  initial begin : cut_model
    logic [VEC_W-1:0] v1;
    logic [VEC_W-1:0] v2;
    v1 = '0;
    v2 = '0;
    forever begin
      @(posedge I1470);
      #1;
      resp = cut_en ? cut_f(v2) : 1'b0;
      v2   = v1;
      v1   = vec;
    end
  end

  initial begin : monitor
    forever begin
      @(negedge I1470);
      if (I1477 && vec_valid) begin
        if (exp_vec_q.size() == 0) check("vec_valid unexpected", {31'b0, vec_valid}, 32'd0);
        else                       check("vec", {26'b0, vec}, {26'b0, exp_vec_q.pop_front()});
      end
      if (I1477 && done) begin
        if (exp_sig_q.size() == 0) check("done unexpected", {31'b0, done}, 32'd0);
        else                       check("sig at done", {16'b0, sig}, {16'b0, exp_sig_q.pop_front()});
      end
    end
  end

  task automatic do_run(input logic [SIG_W-1:0] s, input bit with_abort,
                        output logic [VEC_W-1:0] first_vec);
    logic [SIG_W-1:0] exp;
    exp = model_run(s, PAT_CNT);
    exp_sig_q.push_back(exp);
    @(negedge I1470);
    start = 1'b1;
    seed  = s;
    abort = with_abort;
    @(negedge I1470);
    start = 1'b0;
    abort = 1'b0;
    first_vec = vec;
    for (int c = 1; c <= RUN_LEN; c++) begin
      if (c > 1) @(negedge I1470);
      check($sformatf("c%0d vec_valid", c), {31'b0, vec_valid}, {31'b0, (c <= PAT_CNT)});
      check($sformatf("c%0d busy", c), {31'b0, busy}, {31'b0, (c <= PAT_CNT + CUT_LAT)});
      check($sformatf("c%0d done", c), {31'b0, done}, {31'b0, (c == PAT_CNT + CUT_LAT + 1)});
      if (c > PAT_CNT && c <= PAT_CNT + CUT_LAT)
        check($sformatf("c%0d drain vec", c), {26'b0, vec}, 32'd0);
    end
    check("sig held", {16'b0, sig}, {16'b0, exp});
    check("vec queue drained", exp_vec_q.size(), 32'd0);
    check("sig queue drained", exp_sig_q.size(), 32'd0);
`ifdef NT_BIST_GOLDEN_CMP_EN
    check("pass", {31'b0, pass}, {31'b0, (exp == golden)});
`endif
    last_sig = exp;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [VEC_W-1:0] fv;
    logic [SIG_W-1:0] s;

    #1 I1477 = 1'b0;
    #1;
    check("rst vec", {26'b0, vec}, 32'd0);
    check("rst vec_valid", {31'b0, vec_valid}, 32'd0);
    check("rst busy", {31'b0, busy}, 32'd0);
    check("rst done", {31'b0, done}, 32'd0);
    check("rst sig", {16'b0, sig}, 32'd0);
`ifdef NT_BIST_GOLDEN_CMP_EN
    check("rst pass", {31'b0, pass}, 32'd0);
`endif
    repeat (3) @(negedge I1470);
    I1477 = 1'b1;
    @(negedge I1470);
    check("idle busy", {31'b0, busy}, 32'd0);

    // resp tied low: signature stays zero
    cut_en = 1'b0;
`ifdef NT_BIST_GOLDEN_CMP_EN
    golden = 16'h0000;
`endif
    do_run(16'hACE1, 1'b0, fv);
    check("first vec seed ACE1", {26'b0, fv}, 32'h21);
    check("sig zero", {16'b0, sig}, 32'd0);
`ifdef NT_BIST_GOLDEN_CMP_EN
    check("pass golden 0", {31'b0, pass}, 32'd1);
    golden = 16'h1234;
    do_run(16'hACE1, 1'b0, fv);
    check("pass golden 1234", {31'b0, pass}, 32'd0);
`endif

    // reference CUT in the loop
    cut_en   = 1'b1;
    cut_mask = 6'h2D;
    do_run(16'hACE1, 1'b0, fv);
    do_run(16'h0000, 1'b0, fv);
    check("first vec zero seed", {26'b0, fv}, 32'h01);

    // random seeds, masks, and start+abort collisions in IDLE
    repeat (8) begin
      s        = 16'($urandom);
      cut_mask = 6'($urandom);
`ifdef NT_BIST_GOLDEN_CMP_EN
      golden   = 16'($urandom);
`endif
      do_run(s, 1'($urandom_range(0, 1)), fv);
    end

    // abort in cycle 2
    s = 16'($urandom);
    void'(model_run(s, 2));
    @(negedge I1470);
    start = 1'b1;
    seed  = s;
    @(negedge I1470);
    start = 1'b0;
    @(negedge I1470);
    abort = 1'b1;
    @(negedge I1470);
    abort = 1'b0;
    check("abort vec_valid", {31'b0, vec_valid}, 32'd0);
    check("abort busy", {31'b0, busy}, 32'd0);
    repeat (6) begin
      @(negedge I1470);
      check("abort no done", {31'b0, done}, 32'd0);
      check("abort sig kept", {16'b0, sig}, {16'b0, last_sig});
    end
    check("abort vec queue", exp_vec_q.size(), 32'd0);
    do_run(16'($urandom), 1'b0, fv);

    // asynchronous reset in cycle 3
    s = 16'($urandom);
    void'(model_run(s, 3));
    @(negedge I1470);
    start = 1'b1;
    seed  = s;
    @(negedge I1470);
    start = 1'b0;
    @(negedge I1470);
    @(negedge I1470);
    #2 I1477 = 1'b0;
    #1;
    check("midrst vec", {26'b0, vec}, 32'd0);
    check("midrst vec_valid", {31'b0, vec_valid}, 32'd0);
    check("midrst busy", {31'b0, busy}, 32'd0);
    check("midrst sig", {16'b0, sig}, 32'd0);
    last_sig = '0;
    @(negedge I1470);
    @(negedge I1470);
    I1477 = 1'b1;
    check("midrst vec queue", exp_vec_q.size(), 32'd0);
    do_run(s, 1'b0, fv);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/nt_bist_stimulus_driver.md
Name: nt_bist_stimulus_driver

Overview:
- Transmit-side test harness for Nt-node subcircuits.
- Generates pseudo-random input vectors with a 16-bit LFSR and drives them onto the subcircuit-under-test (CUT) inputs.
- Captures the 1-bit CUT response after a fixed pipeline latency and compacts it into a 16-bit MISR signature.
- Sits between the benchmark controller and one CUT instance. It is the stimulus/observe counterpart of the flop-based subcircuits.

Parameters:
- VEC_W, 6: width of the stimulus vector driven to the CUT.
- PAT_CNT, 1000: number of vectors issued per run; minimum 1.
- CUT_LAT, 2: CUT register depth in cycles from vector to response; range 0..7.
- SIG_W, 16: LFSR/MISR width; fixed at 16.

Ports:
- I1470  in  1  clock; all state on its rising edge.
- I1477  in  1  reset; asynchronous, active-low.
- start  in  1  single-cycle pulse that begins a run when IDLE.
- abort  in  1  terminates a run and returns to IDLE.
- seed  in  16  LFSR seed, sampled on accepted start.
- vec  out  VEC_W  stimulus vector to the CUT.
- vec_valid  out  1  vec is a live pattern this cycle.
- resp  in  1  CUT output.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  single-cycle pulse when the signature is final.
- sig  out  16  MISR signature; held stable after done until the next start.

Behaviour:
- Reset (I1477 low) values: state=IDLE; vec=0, vec_valid=0, busy=0, done=0, sig=0; LFSR=0x0001; counters=0.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE -> RUN on start.
  - LFSR<=seed; a zero seed is replaced by 0x0001.
  - MISR<=0; pattern counter<=0.
- RUN: vec_valid=1 and vec=LFSR[VEC_W-1:0] for exactly PAT_CNT consecutive cycles, starting the cycle after start.
  - LFSR steps every RUN cycle.
  - Fibonacci taps 16,14,13,11; new bit0 = b15^b13^b12^b10; shift left.
- RUN -> DRAIN after the PAT_CNT-th vector. If CUT_LAT=0, go directly to DONE.
- DRAIN: vec_valid=0, vec held at 0; lasts CUT_LAT cycles.
- Response capture:
  - A valid-shift pipeline of depth CUT_LAT tracks vec_valid.
  - When the delayed valid is 1, resp is folded into the MISR: next = {MISR[14:0], fb} ^ {15'b0, resp}, where fb uses the LFSR taps.
- Timing: the last capture occurs in the final DRAIN cycle. DONE is entered next, so done pulses at (last vec_valid cycle)+CUT_LAT+1.
- DONE: one cycle, done=1, sig=MISR. Then return to IDLE.
- busy=1 exactly in RUN and DRAIN.
- start while busy or in DONE: ignored.
- abort in RUN or DRAIN: next state IDLE, vec_valid=0, no done pulse, sig unchanged.
- abort and start in the same cycle while IDLE: start wins.
- Pattern counter is 10 bits. It never wraps, because the terminal compare is on PAT_CNT-1.
- Reset asserted mid-run: all state returns to reset values immediately (asynchronous).

Optional Feature:
- Macro: NT_BIST_GOLDEN_CMP_EN.
- When defined:
  - Adds input golden[15:0] and output pass[0:0].
  - pass is registered in DONE as (MISR==golden) and held until the next accepted start.
  - pass resets to 0.
- When undefined: neither port exists, and no comparator logic is built.

Decomposition:
- Shared package nt_bist_pkg holds:
  - the state enum typedef;
  - the LFSR tap constant 16'hB400;
  - the SIG_W constant;
  - the zero-seed substitute constant 16'h0001.
- One sub-module, nt_bist_lfsr16: a step-enabled 16-bit LFSR with an optional parallel XOR input. It is instantiated twice: once as the pattern LFSR (XOR input tied 0) and once as the MISR.

Test Plan:
- PAT_CNT=4, CUT_LAT=2, seed=0xACE1, resp tied 0, start at cycle 0 -> vec_valid high in cycles 1–4, first vec=0x21, busy high in cycles 1–6, done pulses in cycle 7, sig=0x0000.
- Same setup with resp driven by a reference-model CUT -> sig equals the model's MISR value. The vec sequence matches the model LFSR for all 4 vectors.
- seed=0x0000 -> first vec=0x01 (substitute seed applied).
- abort asserted in cycle 2 of a PAT_CNT=4 run -> state IDLE in cycle 3, vec_valid=0, no done pulse, sig keeps its prior value. A following start runs normally.
- I1477 pulled low in cycle 3 of a run -> all outputs 0 immediately. After release, start produces a full, correct run.
- With NT_BIST_GOLDEN_CMP_EN, golden=0x0000 and resp tied 0 -> pass=1 after done. With golden=0x1234 -> pass=0.
